// File: rtl/rvfi_reg_driver_pkg.sv
// rtl/rvfi_reg_driver_pkg.sv - shared widths and command record for the RVFI register driver
package rvfi_reg_driver_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int MAX_XLEN     = 64;
  localparam int ORDER_W      = 8;
  localparam int REG_ADDR_W   = 5;
  localparam int INSN_W       = 32;
  localparam int NUM_REGS     = 32;

  // wdata is sized for the widest supported XLEN; narrower builds zero-extend
  typedef struct packed {
    logic [INSN_W-1:0]     insn;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [MAX_XLEN-1:0]   wdata;
    logic                  fault;
  } cmd_t;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rvfi_reg_driver_fifo.sv
// rtl/rvfi_reg_driver_fifo.sv - synchronous power-of-two command FIFO
module rvfi_reg_driver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // a full FIFO refuses pushes even when a pop happens in the same cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rd_ptr];

  // storage array, no reset needed since contents are qualified by count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_reg_driver.sv
// rtl/rvfi_reg_driver.sv - in-order RVFI retirement producer backed by an architectural register file
module rvfi_reg_driver
  import rvfi_reg_driver_pkg::*;
#(
  parameter int                  XLEN      = XLEN_DEFAULT,
  parameter int                  DEPTH     = 4,
  parameter bit                  ZERO_INIT = 1'b1,
  parameter logic [MAX_XLEN-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [INSN_W-1:0]     cmd_insn,
  input  logic [REG_ADDR_W-1:0] cmd_rs1_addr,
  input  logic [REG_ADDR_W-1:0] cmd_rs2_addr,
  input  logic [REG_ADDR_W-1:0] cmd_rd_addr,
  input  logic [XLEN-1:0]       cmd_rd_wdata,
  input  logic                  cmd_inject_fault,
  input  logic                  out_stall,
  output logic                  rvfi_valid,
  output logic [ORDER_W-1:0]    rvfi_order,
  output logic [INSN_W-1:0]     rvfi_insn,
  output logic [REG_ADDR_W-1:0] rvfi_rs1_addr,
  output logic [REG_ADDR_W-1:0] rvfi_rs2_addr,
  output logic [REG_ADDR_W-1:0] rvfi_rd_addr,
  output logic [XLEN-1:0]       rvfi_rs1_rdata,
  output logic [XLEN-1:0]       rvfi_rs2_rdata,
  output logic [XLEN-1:0]       rvfi_rd_wdata,
  output logic [XLEN-1:0]       rvfi_pc_rdata,
  output logic [XLEN-1:0]       rvfi_pc_wdata,
  output logic                  rvfi_trap
);

  cmd_t               in_cmd;
  cmd_t               head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [XLEN-1:0]    regs [NUM_REGS];
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    rd_val;
  logic [XLEN-1:0]    pc;
  logic [ORDER_W-1:0] retire_cnt;

  // pack the incoming command fields into the queue record
  always_comb begin
    in_cmd       = '0;
    in_cmd.insn  = cmd_insn;
    in_cmd.rs1   = cmd_rs1_addr;
    in_cmd.rs2   = cmd_rs2_addr;
    in_cmd.rd    = cmd_rd_addr;
    in_cmd.wdata = MAX_XLEN'(cmd_rd_wdata);
    in_cmd.fault = cmd_inject_fault;
  end

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = !empty && !out_stall;
  assign rvfi_trap = 1'b0;

  rvfi_reg_driver_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (in_cmd),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // operand reads see the register file before this command's own write
  assign rs1_val = is_x0(head.rs1) ? '0 : regs[head.rs1];
  assign rs2_val = is_x0(head.rs2) ? '0 : regs[head.rs2];
  assign rd_val  = is_x0(head.rd)  ? '0 : XLEN'(head.wdata);

  // architectural register file; contents survive reset unless ZERO_INIT
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (ZERO_INIT) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          regs[i] <= '0;
        end
      end
    end else if (pop && !is_x0(head.rd)) begin
      regs[head.rd] <= rd_val;
    end
  end

  // retirement packet registers; data fields hold between retirements
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      pc             <= XLEN'(RESET_PC);
      retire_cnt     <= '0;
    end else begin
      rvfi_valid <= pop;
      if (pop) begin
        rvfi_order     <= retire_cnt;
        rvfi_insn      <= head.insn;
        rvfi_rs1_addr  <= head.rs1;
        rvfi_rs2_addr  <= head.rs2;
        rvfi_rd_addr   <= head.rd;
        rvfi_rs1_rdata <= rs1_val ^ {{(XLEN-1){1'b0}}, head.fault};
        rvfi_rs2_rdata <= rs2_val;
        rvfi_rd_wdata  <= rd_val;
        rvfi_pc_rdata  <= pc;
        rvfi_pc_wdata  <= pc + XLEN'(4);
        pc             <= pc + XLEN'(4);
        retire_cnt     <= retire_cnt + ORDER_W'(1);
      end
    end
  end

endmodule

// File: doc/rvfi_reg_driver.md
Name: rvfi_reg_driver

Overview:
RVFI producer for single-channel retirement traces (NRET=1). It accepts abstract instruction commands (rs1/rs2/rd addresses, rd write data, insn word) over a valid/ready handshake and buffers them. It retires them in order against an internal 32-entry architectural register file, emitting architecturally consistent rvfi_* packets. Used as the transmitting end for register-consistency and ordering checkers, with an optional per-command fault injection for negative checker tests.

Parameters:
XLEN, 32, register and PC width (32 or 64)
DEPTH, 4, command FIFO entries, power of two, >= 2
ZERO_INIT, 1, 1 = register file cleared on reset; 0 = register contents retained across reset
RESET_PC, 0, rvfi_pc_rdata of the first retirement after reset

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command
cmd_insn  input  32  instruction word, passed through unchanged
cmd_rs1_addr  input  5  source register 1
cmd_rs2_addr  input  5  source register 2
cmd_rd_addr  input  5  destination register
cmd_rd_wdata  input  XLEN  value written to rd
cmd_inject_fault  input  1  corrupt reported rs1_rdata for this command
out_stall  input  1  inhibit retirement this cycle
rvfi_valid  output  1  retirement valid
rvfi_order  output  8  retirement index, wraps
rvfi_insn  output  32  retired instruction word
rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  output  5 each  retired addresses
rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  output  XLEN each  register values
rvfi_pc_rdata, rvfi_pc_wdata  output  XLEN each  PC before and after retirement
rvfi_trap  output  1  constant 0

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low.
- Reset values: rvfi_valid=0, rvfi_order=0, all rvfi_* data=0, FIFO empty, cmd_ready=1 in the first cycle after reset, internal PC=RESET_PC.
- Reset mid-operation flushes all queued commands; no packet is emitted for them.
- Register file is cleared only when ZERO_INIT=1.
- Handshake: transfer on cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = !full, independent of cmd_valid and of a same-cycle pop. A full FIFO does not accept, even while popping.
  - The FIFO holds all cmd_* fields.
- Retire: at each edge where the FIFO is non-empty && !out_stall && resetn, the head is popped. On the next cycle the outputs show:
  - rvfi_valid=1 and the head's insn and addresses.
  - rs1_rdata = regs[rs1] and rs2_rdata = regs[rs2], read at pop time. Reads of x0 return 0.
  - rd_wdata = cmd_rd_wdata, or 0 when rd_addr=0.
  - pc_rdata = current PC; pc_wdata = PC+4, modulo 2^XLEN. The internal PC then advances.
  - rvfi_order increments after every retirement and wraps 255 -> 0.
- Cycles with no pop: rvfi_valid=0; data outputs hold their last values.
- Register write: regs[rd] <= rd_wdata at the pop edge when rd != 0. The next retirement (earliest the following cycle) observes the new value. x0 is never written.
- Same-command RAW (rs1==rd): the reported rs1_rdata is the pre-write value.
- Fault: if inject_fault is set, rvfi_rs1_rdata bit 0 is inverted in the packet only. Register file contents are unaffected.
- Latency: accepted at edge t into an empty FIFO with no stall -> rvfi_valid at cycle t+2. Throughput is 1 retirement/cycle.
- Simultaneous push and pop with the FIFO not full: both occur and occupancy is unchanged.

Decomposition:
- Shared package: XLEN default, RVFI field widths (ORDER_W=8, REG_ADDR_W=5, INSN_W=32), and a packed command struct (insn, rs1, rs2, rd, wdata, fault).
- One sub-module: rvfi_reg_driver_fifo. It is a synchronous DEPTH-entry FIFO with push/pop/full/empty, count width log2(DEPTH)+1, and pointer wrap-around.

Test Plan:
- Reset, then cmd (rd=5, wdata=0xDEADBEEF) followed by cmd (rs1=5, rs2=0, rd=6, wdata=1) -> order 0 then 1; second packet rs1_rdata=0xDEADBEEF, rs2_rdata=0; pc_rdata 0,4 and pc_wdata 4,8.
- cmd with rd=0, wdata=0x1234, then read rs1=0 -> first packet rd_wdata=0; second rs1_rdata=0.
- out_stall held high, 5 commands offered -> 4 accepted, cmd_ready=0 after the 4th. Release stall -> 4 consecutive rvfi_valid cycles, then the 5th is accepted and retired.
- 300 back-to-back commands -> rvfi_order wraps 255 -> 0; no rvfi_valid gaps after the first.
- Write x3=0xA, then read x3 with inject_fault=1 -> rs1_rdata=0xB. A subsequent unfaulted read of x3 returns 0xA.
- Assert resetn=0 for one cycle with 3 commands queued -> no packets for them. Next retirement has order=0 and pc_rdata=RESET_PC; with ZERO_INIT=1 every register reads 0.
